// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants for the UART TX scheduler: FSM encoding, default byte width, source indices.
package uart_tx_scheduler_pkg;

  localparam int unsigned DataWidth = 8;

  localparam logic SrcRf  = 1'b0;
  localparam logic SrcAlu = 1'b1;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StSend     = 2'b01,
    StWaitDone = 2'b10
  } state_e;

endpackage

// File: rtl/tx_src_buffer.sv
// One-entry holding register for a TX source; ready is registered and drops after capture.
module tx_src_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             free,
  output logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             ovf
);

  logic             ready_q;
  logic [WIDTH-1:0] data_q;

  // Capture and free are exclusive: free only comes while the entry is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b1;
      data_q  <= '0;
    end else if (valid && ready_q) begin
      ready_q <= 1'b0;
      data_q  <= data_in;
    end else if (free) begin
      ready_q <= 1'b1;
    end
  end

  assign ready    = ready_q;
  assign data_out = data_q;
  assign ovf      = valid & ~ready_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding RF bytes and 2-byte ALU results (LSB first) to a UART TX,
// with a busy-handshake timeout and sticky error flags.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DataWidth,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rf_valid_in,
  input  logic [DATA_WIDTH-1:0]   rf_data_in,
  output logic                    rf_ready_out,
  input  logic                    alu_valid_in,
  input  logic [2*DATA_WIDTH-1:0] alu_data_in,
  output logic                    alu_ready_out,
  input  logic                    tx_busy_in,
  output logic [DATA_WIDTH-1:0]   tx_data_out,
  output logic                    tx_data_valid_out,
  output logic                    ctrl_busy_out,
  output logic [1:0]              ovf_out,
  output logic                    timeout_out,
  input  logic                    clr_err_in
);

  localparam int unsigned CntW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  state_e                  state_q;
  logic                    grant_q;
  logic                    last_grant_q;
  logic                    byte_idx_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    tx_valid_q;
  logic                    busy_q;
  logic [CntW-1:0]         tmo_cnt_q;
  logic [1:0]              ovf_q;
  logic                    timeout_q;

  logic                    rf_ready, alu_ready;
  logic                    rf_full, alu_full;
  logic                    rf_ovf, alu_ovf;
  logic                    rf_free, alu_free;
  logic [DATA_WIDTH-1:0]   rf_byte;
  logic [2*DATA_WIDTH-1:0] alu_word;
  logic                    next_grant;
  logic                    tmo_hit;

  tx_src_buffer #(
    .WIDTH(DATA_WIDTH)
  ) u_rf_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid    (rf_valid_in),
    .data_in  (rf_data_in),
    .free     (rf_free),
    .ready    (rf_ready),
    .data_out (rf_byte),
    .ovf      (rf_ovf)
  );

  tx_src_buffer #(
    .WIDTH(2 * DATA_WIDTH)
  ) u_alu_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid    (alu_valid_in),
    .data_in  (alu_data_in),
    .free     (alu_free),
    .ready    (alu_ready),
    .data_out (alu_word),
    .ovf      (alu_ovf)
  );

  always_comb begin
    rf_full  = ~rf_ready;
    alu_full = ~alu_ready;
    if (rf_full && alu_full) begin
      next_grant = ~last_grant_q;
    end else begin
      next_grant = rf_full ? SrcRf : SrcAlu;
    end
    // Busy seen in the same cycle as the last count takes precedence over the timeout.
    tmo_hit  = (state_q == StSend) && !tx_busy_in && (tmo_cnt_q == CntW'(BUSY_TIMEOUT - 1));
    rf_free  = (state_q == StSend) && (grant_q == SrcRf) && (tx_busy_in || tmo_hit);
    alu_free = (state_q == StSend) && (grant_q == SrcAlu) &&
               ((tx_busy_in && byte_idx_q) || tmo_hit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= SrcRf;
      last_grant_q <= SrcAlu;
      byte_idx_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      tmo_cnt_q    <= '0;
      ovf_q        <= 2'b00;
      timeout_q    <= 1'b0;
    end else begin
      ovf_q     <= (clr_err_in ? 2'b00 : ovf_q) | {alu_ovf, rf_ovf};
      timeout_q <= (clr_err_in ? 1'b0 : timeout_q) | tmo_hit;
      unique case (state_q)
        StIdle: begin
          if (rf_full || alu_full) begin
            grant_q      <= next_grant;
            last_grant_q <= next_grant;
            byte_idx_q   <= 1'b0;
            tx_data_q    <= (next_grant == SrcAlu) ? alu_word[DATA_WIDTH-1:0] : rf_byte;
            tx_valid_q   <= 1'b1;
            tmo_cnt_q    <= '0;
            busy_q       <= 1'b1;
            state_q      <= StSend;
          end
        end
        StSend: begin
          if (tx_busy_in) begin
            tx_valid_q <= 1'b0;
            state_q    <= StWaitDone;
          end else if (tmo_hit) begin
            // Drop the whole frame, including any unsent ALU MSB.
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            byte_idx_q <= 1'b0;
            state_q    <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!tx_busy_in) begin
            if ((grant_q == SrcAlu) && !byte_idx_q) begin
              byte_idx_q <= 1'b1;
              tx_data_q  <= alu_word[2*DATA_WIDTH-1:DATA_WIDTH];
              tx_valid_q <= 1'b1;
              tmo_cnt_q  <= '0;
              state_q    <= StSend;
            end else begin
              byte_idx_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rf_ready_out      = rf_ready;
  assign alu_ready_out     = alu_ready;
  assign tx_data_out       = tx_data_q;
  assign tx_data_valid_out = tx_valid_q;
  assign ctrl_busy_out     = busy_q;
  assign ovf_out           = ovf_q;
  assign timeout_out       = timeout_q;

endmodule
